// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// rtl/serial_subtractor_fs_cell.sv - combinational full-subtractor bit from two half-subtractors
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First stage subtracts y from x, second stage subtracts the incoming borrow.
    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial A-B with start/busy handshake
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] sd_next;

    fs_cell u_fs_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // The difference register fills from the top so the first bit lands at bit 0.
    assign sd_next = {fs_d, sd_q[WIDTH-1:1]};

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        sd_d         = sd_q;
        cnt_d        = cnt_q;
        brw_d        = brw_q;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    sd_d    = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_next;
                brw_d = fs_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d       = sd_next;
                    borrow_out_d = fs_bout;
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sd_q         <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sd_q         <= sd_d;
            cnt_q        <= cnt_d;
            brw_q        <= brw_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int failures = 0;

    exp_t         sb_q[$];
    int           m_rem = 0;
    logic         exp_done = 1'b0;
    logic [W-1:0] held_diff = '0;
    logic         held_borrow = 1'b0;
    logic         mon_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Timing model of the handshake: remaining busy cycles and expected done pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem       <= 0;
            exp_done    <= 1'b0;
            held_diff   <= '0;
            held_borrow <= 1'b0;
            sb_q.delete();
        end else begin
            exp_done <= (m_rem == 1);
            if (m_rem == 0 && start) m_rem <= W;
            else if (m_rem != 0)     m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("busy", busy, m_rem != 0);
            check("done", done, exp_done);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_without_request", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("diff", diff, e.diff);
                    check("borrow_out", borrow_out, e.borrow);
                    held_diff   = e.diff;
                    held_borrow = e.borrow;
                end
            end else begin
                check("diff_hold", diff, held_diff);
                check("borrow_hold", borrow_out, held_borrow);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] d, input logic br);
        exp_t e;
        e.diff   = d;
        e.borrow = br;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ed, input logic eb);
        @(posedge clk); #1;
        a = ia;
        b = ib;
        start = 1'b1;
        push_exp(ed, eb);
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        repeat (W) @(posedge clk);
        #1;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow_out, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow);

        // start held through the whole operation, then relaunched on the done cycle
        @(posedge clk); #1;
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        push_exp(8'h7F, 1'b0);
        @(posedge clk); #1;
        a = 8'h00;
        b = 8'h00;
        push_exp(8'h00, 1'b0);
        repeat (W) @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;

        // reset in the middle of an operation
        run_op(8'h5A, 8'h23, 8'h37, 1'b0);
        @(posedge clk); #1;
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        push_exp(8'h02, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'h05, 8'h03, 8'h02, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, ra - rb, ra < rb);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
